mmio_port: RTL
==============

MMIO_PORT -- requirements
Module: mmio_port

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data word width.
REQ-002 The block SHALL have parameter IN_DEPTH, default 4, meaning the input FIFO depth in words (power of two, at least 2).
REQ-003 The block SHALL have parameter OUT_DEPTH, default 4, meaning the output FIFO depth in words (power of two, at least 2).
REQ-004 clk  input  1  SHALL be the single clock; every flop is rising-edge triggered.
REQ-005 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 in_data  input  WIDTH  SHALL carry the external input word.
REQ-007 in_valid  input  1  SHALL mean the external source offers in_data.
REQ-008 in_accept  output  1  SHALL mean the input FIFO can take a word; it equals the inverse of in_full.
REQ-009 cpu_addr  input  1  SHALL select the register: 0 = DATA, 1 = STATUS.
REQ-010 cpu_rd_en  input  1  SHALL be the CPU read strobe.
REQ-011 cpu_wr_en  input  1  SHALL be the CPU write strobe.
REQ-012 cpu_wr_data  input  WIDTH  SHALL carry the CPU write word.
REQ-013 cpu_rd_data  output  WIDTH  SHALL be the combinational read result.
REQ-014 out_data  output  WIDTH  SHALL be the head of the output FIFO.
REQ-015 out_valid  output  1  SHALL mean the output FIFO is non-empty.
REQ-016 out_ack  input  1  SHALL mean the external sink consumes out_data.

Function
REQ-017 An input push SHALL occur on a clock edge when in_valid and in_accept are both 1.
REQ-018 When the input FIFO is full, in_accept SHALL be 0 even if a CPU pop happens in the same cycle; no bypass path exists.
REQ-019 A DATA read SHALL return the input FIFO head combinationally and pop it at the clock edge.
REQ-020 A DATA read while the input FIFO is empty SHALL return 0, SHALL not pop, and SHALL set sticky UNDERFLOW.
REQ-021 A DATA write SHALL push cpu_wr_data to the output FIFO; when that FIFO is full the word SHALL be dropped and sticky OVERFLOW set.
REQ-022 A STATUS read SHALL return bit0 = input non-empty, bit1 = output full, bit2 = UNDERFLOW, bit3 = OVERFLOW, bits[15:8] = input occupancy, bits[23:16] = output occupancy, and all other bits 0.
REQ-023 A STATUS read SHALL clear UNDERFLOW and OVERFLOW at the clock edge, unless a new error event occurs in that same cycle, in which case the bit stays set.
REQ-024 STATUS writes SHALL be ignored.
REQ-025 If cpu_rd_en and cpu_wr_en are asserted together, the read SHALL take priority and the write SHALL be ignored.
REQ-026 An output pop SHALL occur on a clock edge when out_valid and out_ack are both 1; out_ack while empty SHALL have no effect.
REQ-027 A CPU push and an external pop in the same cycle on a full output FIFO SHALL both take effect, leaving occupancy unchanged.
REQ-028 FIFO pointers SHALL wrap modulo depth.
REQ-029 Occupancy SHALL be held in log2(depth)+1 bits.
REQ-030 When cpu_rd_en is 0, cpu_rd_data SHALL be 0.

Reset
REQ-031 On rst low, both FIFOs SHALL empty immediately: in_accept=1, out_valid=0, out_data=0, sticky bits=0, cpu_rd_data=0.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered words with no partial push or pop.

Configuration
REQ-033 With MMIO_PORT_IRQ_EN defined, the block SHALL add output irq (1 bit), registered, equal to input non-empty OR UNDERFLOW OR OVERFLOW, and reset to 0.
REQ-034 Without MMIO_PORT_IRQ_EN, the irq port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-035 Package mmio_pkg SHALL hold the address constants ADDR_DATA and ADDR_STATUS and the STATUS bit positions.
REQ-036 A sub-module sync_fifo (parameters WIDTH and DEPTH, with push/pop/full/empty/count) SHALL be instantiated twice, once per direction.

Verification
REQ-037 Reset then in_data=5 with in_valid=1 for one cycle, then a DATA read -> cpu_rd_data=5, and a following STATUS read returns bit0=0.
REQ-038 Push 4 words with IN_DEPTH=4 -> in_accept=0, STATUS[15:8]=4; a fifth word offered is not taken.
REQ-039 DATA read while empty -> cpu_rd_data=0, STATUS bit2=1; a second STATUS read returns bit2=0.
REQ-040 CPU writes 0xA,0xB,0xC,0xD,0xE with out_ack=0 -> OVERFLOW set, out_data=0xA; pulsing out_ack yields 0xA..0xD in order.
REQ-041 Output FIFO full, DATA write and out_ack in the same cycle -> occupancy stays 4 and the new word appears last.
REQ-042 With MMIO_PORT_IRQ_EN, one input push -> irq=1 one cycle later; rst low mid-stream -> irq=0, out_valid=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
//   Shared constants for the mmio_port block.
//   - CPU register addresses (cpu_addr is a single bit).
//   - Bit positions and field widths inside the STATUS register.
//   - Helper that narrows a FIFO occupancy count into an 8-bit STATUS field.
// -----------------------------------------------------------------------------
package mmio_pkg;

    // Register map (cpu_addr is one bit wide)
    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    // STATUS register layout; every bit not listed here reads as zero
    localparam int ST_IN_NONEMPTY = 0;
    localparam int ST_OUT_FULL    = 1;
    localparam int ST_UNDERFLOW   = 2;
    localparam int ST_OVERFLOW    = 3;
    localparam int ST_IN_CNT_LSB  = 8;
    localparam int ST_OUT_CNT_LSB = 16;
    localparam int ST_CNT_W       = 8;

    // Occupancy counts are log2(depth)+1 bits wide. They are zero-extended
    // (or truncated for very deep FIFOs) into the 8-bit STATUS field.
    function automatic logic [ST_CNT_W-1:0] cnt_field(input logic [31:0] cnt);
        return cnt[ST_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with a combinational head and an occupancy counter.
//
//   Parameters
//     WIDTH   word width
//     DEPTH   depth in words (power of two, at least 2)
//
//   Ports
//     clk      rising-edge clock
//     rst      asynchronous active-low reset, empties the FIFO
//     push     write request; taken when not full, or when full and a pop
//              is taken in the same cycle (the freed slot is reused)
//     wr_data  word written on an accepted push
//     pop      read request; ignored while empty
//     rd_data  head word, forced to 0 while empty
//     full     count == DEPTH
//     empty    count == 0
//     count    occupancy, log2(DEPTH)+1 bits
//
//   Handshake: a push (pop) happens on a rising edge when the request is high
//   and the FIFO can take (supply) a word; a request that cannot be honoured
//   is simply not performed, it is never queued for a later cycle.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is masked so an empty FIFO presents 0 rather than stale storage.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_port.sv
// -----------------------------------------------------------------------------
// mmio_port
//   Memory-mapped port between a CPU and two external streams. An input FIFO
//   buffers words from an external source for the CPU to read; an output FIFO
//   buffers CPU-written words for an external sink.
//
//   Parameters
//     WIDTH      data word width (STATUS fields need WIDTH >= 24)
//     IN_DEPTH   input FIFO depth (power of two, at least 2)
//     OUT_DEPTH  output FIFO depth (power of two, at least 2)
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous active-low reset
//     in_data      external input word
//     in_valid     external source offers in_data
//     in_accept    input FIFO can take a word (= !in_full)
//     cpu_addr     0 = DATA, 1 = STATUS
//     cpu_rd_en    CPU read strobe (wins over cpu_wr_en)
//     cpu_wr_en    CPU write strobe
//     cpu_wr_data  CPU write word
//     cpu_rd_data  combinational read result, 0 when not reading
//     out_data     output FIFO head (0 when empty)
//     out_valid    output FIFO non-empty
//     out_ack      external sink consumes out_data
//     irq          only with MMIO_PORT_IRQ_EN defined: registered
//                  (input non-empty | UNDERFLOW | OVERFLOW)
//
//   Handshake: both external streams use valid/ready semantics. A word moves
//   on a rising edge exactly when the offering side's valid (in_valid,
//   out_valid) and the receiving side's ready (in_accept, out_ack) are both
//   high; neither side may make the transfer depend on a later cycle.
//
//   Register behaviour
//     DATA read    returns input head and pops it; if empty returns 0, no pop,
//                  sets sticky UNDERFLOW.
//     DATA write   pushes to the output FIFO; if full (and not popped by the
//                  sink in the same cycle) the word is dropped and sticky
//                  OVERFLOW is set.
//     STATUS read  returns flags and occupancies, clears the sticky bits.
//     STATUS write ignored.
// -----------------------------------------------------------------------------
module mmio_port
    import mmio_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_accept,
    input  logic             cpu_addr,
    input  logic             cpu_rd_en,
    input  logic             cpu_wr_en,
    input  logic [WIDTH-1:0] cpu_wr_data,
    output logic [WIDTH-1:0] cpu_rd_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ack
`ifdef MMIO_PORT_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int ICW = $clog2(IN_DEPTH) + 1;
    localparam int OCW = $clog2(OUT_DEPTH) + 1;

    // FIFO status
    logic [WIDTH-1:0] in_head;
    logic             in_full;
    logic             in_empty;
    logic [ICW-1:0]   in_count;
    logic             out_full;
    logic             out_empty;
    logic [OCW-1:0]   out_count;

    // Decoded CPU access
    logic             rd_data_sel;
    logic             rd_status_sel;
    logic             wr_data_sel;

    // FIFO controls and error events
    logic             in_push;
    logic             in_pop;
    logic             out_push;
    logic             out_pop;
    logic             underflow_evt;
    logic             overflow_evt;

    // Sticky error flags
    logic             underflow;
    logic             overflow;

    logic [WIDTH-1:0] status_word;

    // ---------------------------------------------------------------------
    // Access decode. A read and a write in the same cycle is a read; the
    // write is dropped entirely. STATUS writes decode to nothing.
    // ---------------------------------------------------------------------
    assign rd_data_sel   = cpu_rd_en && (cpu_addr == ADDR_DATA);
    assign rd_status_sel = cpu_rd_en && (cpu_addr == ADDR_STATUS);
    assign wr_data_sel   = cpu_wr_en && !cpu_rd_en && (cpu_addr == ADDR_DATA);

    // ---------------------------------------------------------------------
    // Input direction. in_accept depends only on the full flag, so a CPU
    // pop from a full FIFO does not open a slot until the following cycle.
    // ---------------------------------------------------------------------
    assign in_accept     = !in_full;
    assign in_push       = in_valid && in_accept;
    assign in_pop        = rd_data_sel && !in_empty;
    assign underflow_evt = rd_data_sel && in_empty;

    // ---------------------------------------------------------------------
    // Output direction. A CPU write into a full FIFO still succeeds if the
    // sink pops in the same cycle; only a genuinely dropped word overflows.
    // ---------------------------------------------------------------------
    assign out_valid    = !out_empty;
    assign out_pop      = out_ack && !out_empty;
    assign out_push     = wr_data_sel && (!out_full || out_pop);
    assign overflow_evt = wr_data_sel && out_full && !out_pop;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_push),
        .wr_data (in_data),
        .pop     (in_pop),
        .rd_data (in_head),
        .full    (in_full),
        .empty   (in_empty),
        .count   (in_count)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (out_push),
        .wr_data (cpu_wr_data),
        .pop     (out_pop),
        .rd_data (out_data),
        .full    (out_full),
        .empty   (out_empty),
        .count   (out_count)
    );

    // ---------------------------------------------------------------------
    // STATUS word
    // ---------------------------------------------------------------------
    always_comb begin
        status_word                                 = '0;
        status_word[ST_IN_NONEMPTY]                 = !in_empty;
        status_word[ST_OUT_FULL]                    = out_full;
        status_word[ST_UNDERFLOW]                   = underflow;
        status_word[ST_OVERFLOW]                    = overflow;
        status_word[ST_IN_CNT_LSB +: ST_CNT_W]      = cnt_field(32'(in_count));
        status_word[ST_OUT_CNT_LSB +: ST_CNT_W]     = cnt_field(32'(out_count));
    end

    // Read mux; in_head is already 0 while the input FIFO is empty.
    always_comb begin
        cpu_rd_data = '0;
        if (rd_data_sel) begin
            cpu_rd_data = in_head;
        end else if (rd_status_sel) begin
            cpu_rd_data = status_word;
        end
    end

    // ---------------------------------------------------------------------
    // Sticky flags: a new event in the same cycle as a STATUS read wins, so
    // an error is never lost between the read and the clear.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (underflow_evt) begin
                underflow <= 1'b1;
            end else if (rd_status_sel) begin
                underflow <= 1'b0;
            end
            if (overflow_evt) begin
                overflow <= 1'b1;
            end else if (rd_status_sel) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef MMIO_PORT_IRQ_EN
    // Registered interrupt, one cycle behind the state it summarises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= !in_empty || underflow || overflow;
        end
    end
`endif

endmodule
